// File: rtl/ps2_zx_keyboard.sv
// PS/2 keyboard receiver driving an emulated ZX Spectrum 8x5 key matrix (kd, active-low).
// Optional frame watchdog enabled by defining PS2_WATCHDOG_EN.
module ps2_zx_keyboard #(
  parameter int unsigned TIMEOUT_CYCLES = 3500
) (
  input  logic       clkcpu,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] a_hi,
  output logic [4:0] kd,
  output logic       rx_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  rx_state_t       state_q, state_d;
  logic [1:0]      clk_sync, dat_sync;
  logic            clk_prev;
  logic            fall, dat;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            valid_q, valid_d;
  logic            err_d;
  logic            wd_expired;
  logic            rel_q, ext_q;
  logic [7:0][4:0] matrix;
  logic [6:0]      map_hit;

  // {hit, row, column}; both shift keys share CAPS SHIFT
  function automatic logic [6:0] key_map(input logic [7:0] code);
    case (code)
      8'h12, 8'h59: key_map = {1'b1, 3'd0, 3'd0};
      8'h1A: key_map = {1'b1, 3'd0, 3'd1};
      8'h22: key_map = {1'b1, 3'd0, 3'd2};
      8'h21: key_map = {1'b1, 3'd0, 3'd3};
      8'h2A: key_map = {1'b1, 3'd0, 3'd4};
      8'h1C: key_map = {1'b1, 3'd1, 3'd0};
      8'h1B: key_map = {1'b1, 3'd1, 3'd1};
      8'h23: key_map = {1'b1, 3'd1, 3'd2};
      8'h2B: key_map = {1'b1, 3'd1, 3'd3};
      8'h34: key_map = {1'b1, 3'd1, 3'd4};
      8'h15: key_map = {1'b1, 3'd2, 3'd0};
      8'h1D: key_map = {1'b1, 3'd2, 3'd1};
      8'h24: key_map = {1'b1, 3'd2, 3'd2};
      8'h2D: key_map = {1'b1, 3'd2, 3'd3};
      8'h2C: key_map = {1'b1, 3'd2, 3'd4};
      8'h16: key_map = {1'b1, 3'd3, 3'd0};
      8'h1E: key_map = {1'b1, 3'd3, 3'd1};
      8'h26: key_map = {1'b1, 3'd3, 3'd2};
      8'h25: key_map = {1'b1, 3'd3, 3'd3};
      8'h2E: key_map = {1'b1, 3'd3, 3'd4};
      8'h45: key_map = {1'b1, 3'd4, 3'd0};
      8'h46: key_map = {1'b1, 3'd4, 3'd1};
      8'h3E: key_map = {1'b1, 3'd4, 3'd2};
      8'h3D: key_map = {1'b1, 3'd4, 3'd3};
      8'h36: key_map = {1'b1, 3'd4, 3'd4};
      8'h4D: key_map = {1'b1, 3'd5, 3'd0};
      8'h44: key_map = {1'b1, 3'd5, 3'd1};
      8'h43: key_map = {1'b1, 3'd5, 3'd2};
      8'h3C: key_map = {1'b1, 3'd5, 3'd3};
      8'h35: key_map = {1'b1, 3'd5, 3'd4};
      8'h5A: key_map = {1'b1, 3'd6, 3'd0};
      8'h4B: key_map = {1'b1, 3'd6, 3'd1};
      8'h42: key_map = {1'b1, 3'd6, 3'd2};
      8'h3B: key_map = {1'b1, 3'd6, 3'd3};
      8'h33: key_map = {1'b1, 3'd6, 3'd4};
      8'h29: key_map = {1'b1, 3'd7, 3'd0};
      8'h14: key_map = {1'b1, 3'd7, 3'd1};
      8'h3A: key_map = {1'b1, 3'd7, 3'd2};
      8'h31: key_map = {1'b1, 3'd7, 3'd3};
      8'h32: key_map = {1'b1, 3'd7, 3'd4};
      default: key_map = '0;
    endcase
  endfunction

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall = clk_prev & ~clk_sync[1];
  assign dat  = dat_sync[1];

`ifdef PS2_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else if (state_q == IDLE || fall) wd_q <= '0;
    else wd_q <= wd_q + 1'b1;
  end

  assign wd_expired = (state_q != IDLE) && !fall && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      rx_err  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: if (!dat) begin
          state_d = DATA;
          cnt_d   = '0;
        end
        DATA: begin
          shreg_d = {dat, shreg_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat;
          state_d = STOP;
        end
        STOP: begin
          if (dat && (^{shreg_q, par_q})) valid_d = 1'b1;
          else err_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (wd_expired) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  // shreg_q stays stable until the next start bit, so it is read directly on valid_q
  assign map_hit = key_map(shreg_q);

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      matrix <= '0;
      rel_q  <= 1'b0;
      ext_q  <= 1'b0;
    end else if (valid_q) begin
      case (shreg_q)
        8'hF0: rel_q <= 1'b1;
        8'hE0: ext_q <= 1'b1;
        8'hAA, 8'hFA, 8'hEE: ;
        8'h00, 8'hFF: begin
          matrix <= '0;
          rel_q  <= 1'b0;
          ext_q  <= 1'b0;
        end
        default: begin
          if (map_hit[6] && !ext_q) matrix[map_hit[5:3]][map_hit[2:0]] <= ~rel_q;
          rel_q <= 1'b0;
          ext_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    logic [4:0] pressed;
    pressed = '0;
    for (int unsigned r = 0; r < 8; r++) begin
      pressed = pressed | (matrix[r] & {5{~a_hi[r]}});
    end
    kd = ~pressed;
  end

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Self-checking bench for ps2_zx_keyboard: directed scenarios plus random key traffic
// compared against a table-driven key-matrix model.
module tb_ps2_zx_keyboard;

  logic       clkcpu = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] a_hi;
  logic [4:0] kd;
  logic       rx_err;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;

  ps2_zx_keyboard #(.TIMEOUT_CYCLES(100)) dut (
    .clkcpu (clkcpu),
    .rst_n  (rst_n),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .a_hi   (a_hi),
    .kd     (kd),
    .rx_err (rx_err)
  );

  always #5 clkcpu = ~clkcpu;

  always @(negedge clkcpu) if (rx_err === 1'b1) err_pulses++;

  // Reference model: key index = row*5 + column
  logic [7:0] key_codes [40] = '{
    8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
    8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
    8'h29, 8'h14, 8'h3A, 8'h31, 8'h32};
  bit m_keys [40];
  bit m_rel, m_ext;

  function automatic int key_index(input logic [7:0] b);
    if (b == 8'h59) return 0;
    for (int i = 0; i < 40; i++) if (key_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 40; i++) m_keys[i] = 1'b0;
    m_rel = 1'b0;
    m_ext = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int idx;
    if (b == 8'hF0) m_rel = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hAA || b == 8'hFA || b == 8'hEE) begin end
    else if (b == 8'h00 || b == 8'hFF) model_clear();
    else begin
      idx = key_index(b);
      if (idx >= 0 && !m_ext) m_keys[idx] = !m_rel;
      m_rel = 1'b0;
      m_ext = 1'b0;
    end
  endfunction

  function automatic logic [4:0] model_kd(input logic [7:0] a);
    logic [4:0] v;
    v = 5'b11111;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!a[r] && m_keys[r*5+c]) v[c] = 1'b0;
    return v;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      repeat (4) @(negedge clkcpu);
      ps2_clk = 1'b0;
      repeat (8) @(negedge clkcpu);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clkcpu);
    end
    ps2_dat = 1'b1;
    repeat (8) @(negedge clkcpu);
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
    model_byte(b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1; a_hi = 8'h00;
    model_clear();
    repeat (3) @(negedge clkcpu);
    #1;
    checks++;
    if (kd !== 5'b11111) begin errors++; $display("FAIL reset_kd got=%b exp=%b", kd, 5'b11111); end
    checks++;
    if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_rx_err got=%b exp=0", rx_err); end
    rst_n = 1'b1;
    repeat (4) @(negedge clkcpu);
  endtask

  task automatic test_single_key();
    send_key(8'h1C);
    a_hi = 8'hFD; #1;
    checks++;
    if (kd !== 5'b11110) begin errors++; $display("FAIL press_A got=%b exp=%b", kd, 5'b11110); end
    send_key(8'hF0);
    send_key(8'h1C);
    #1;
    checks++;
    if (kd !== 5'b11111) begin errors++; $display("FAIL release_A got=%b exp=%b", kd, 5'b11111); end
  endtask

  task automatic test_multi_row();
    logic [7:0] sel [3] = '{8'hF6, 8'hF7, 8'hFE};
    send_key(8'h12);
    send_key(8'h16);
    for (int i = 0; i < 3; i++) begin
      a_hi = sel[i]; #1;
      checks++;
      if (kd !== 5'b11110) begin
        errors++; $display("FAIL multi_row a_hi=%h got=%b exp=%b", a_hi, kd, 5'b11110);
      end
    end
    send_key(8'hFF);
    a_hi = 8'h00; #1;
    checks++;
    if (kd !== 5'b11111) begin errors++; $display("FAIL overrun_clear got=%b exp=%b", kd, 5'b11111); end
  endtask

  task automatic test_parity_error();
    int e0;
    e0 = err_pulses;
    send_frame(8'h29, 1'b1, 1'b0, 11);
    a_hi = 8'h7F; #1;
    checks++;
    if (err_pulses - e0 != 1) begin
      errors++; $display("FAIL parity_err_pulses got=%0d exp=1", err_pulses - e0);
    end
    checks++;
    if (kd !== 5'b11111) begin errors++; $display("FAIL parity_no_key got=%b exp=%b", kd, 5'b11111); end
    send_key(8'h29);
    #1;
    checks++;
    if (kd !== 5'b11110) begin errors++; $display("FAIL space_press got=%b exp=%b", kd, 5'b11110); end
  endtask

  task automatic test_framing_error();
    int e0;
    e0 = err_pulses;
    send_frame(8'h22, 1'b0, 1'b1, 11);
    a_hi = 8'hFE; #1;
    checks++;
    if (err_pulses - e0 != 1) begin
      errors++; $display("FAIL stop_err_pulses got=%0d exp=1", err_pulses - e0);
    end
    checks++;
    if (kd !== model_kd(a_hi)) begin
      errors++; $display("FAIL stop_no_key got=%b exp=%b", kd, model_kd(a_hi));
    end
  endtask

  task automatic test_ext_and_overrun();
    send_key(8'hE0);
    send_key(8'h75);
    a_hi = 8'h00; #1;
    checks++;
    if (kd !== model_kd(8'h00)) begin
      errors++; $display("FAIL ext_no_change got=%b exp=%b", kd, model_kd(8'h00));
    end
    send_key(8'h1A);
    a_hi = 8'hFE; #1;
    checks++;
    if (kd !== 5'b11101) begin errors++; $display("FAIL press_Z got=%b exp=%b", kd, 5'b11101); end
    send_key(8'hE0);
    send_key(8'h1A);
    #1;
    checks++;
    if (kd !== 5'b11101) begin errors++; $display("FAIL ext_mapped_drop got=%b exp=%b", kd, 5'b11101); end
    send_key(8'hFF);
    a_hi = 8'h00; #1;
    checks++;
    if (kd !== 5'b11111) begin errors++; $display("FAIL overrun_all got=%b exp=%b", kd, 5'b11111); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] a;
    int sel, e0;
    e0 = err_pulses;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 99);
      if (sel < 55) b = key_codes[$urandom_range(0, 39)];
      else if (sel < 75) b = 8'hF0;
      else if (sel < 82) b = 8'hE0;
      else if (sel < 86) b = 8'hAA;
      else if (sel < 88) b = 8'h59;
      else if (sel < 90) b = 8'hFF;
      else b = 8'($urandom_range(0, 255));
      send_key(b);
      for (int k = 0; k < 2; k++) begin
        a = (k == 0) ? 8'($urandom_range(0, 255)) : ~(8'd1 << $urandom_range(0, 7));
        a_hi = a; #1;
        checks++;
        if (kd !== model_kd(a)) begin
          errors++; $display("FAIL random it=%0d byte=%h a_hi=%h got=%b exp=%b", it, b, a, kd, model_kd(a));
        end
      end
    end
    checks++;
    if (err_pulses != e0) begin
      errors++; $display("FAIL random_no_err got=%0d exp=%0d", err_pulses, e0);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_key(8'h1C);
    send_key(8'h16);
    send_frame(8'h2A, 1'b0, 1'b0, 5);
    @(negedge clkcpu);
    rst_n = 1'b0;
    model_clear();
    a_hi = 8'h00;
    repeat (2) @(negedge clkcpu);
    #1;
    checks++;
    if (kd !== 5'b11111) begin errors++; $display("FAIL mid_reset_clear got=%b exp=%b", kd, 5'b11111); end
    rst_n = 1'b1;
    repeat (4) @(negedge clkcpu);
    send_key(8'h2A);
    a_hi = 8'hFE; #1;
    checks++;
    if (kd !== 5'b01111) begin errors++; $display("FAIL after_reset_V got=%b exp=%b", kd, 5'b01111); end
  endtask

`ifdef PS2_WATCHDOG_EN
  task automatic test_watchdog();
    int e0;
    send_key(8'hFF);
    e0 = err_pulses;
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    repeat (150) @(negedge clkcpu);
    checks++;
    if (err_pulses - e0 != 1) begin
      errors++; $display("FAIL watchdog_err got=%0d exp=1", err_pulses - e0);
    end
    send_key(8'h1C);
    a_hi = 8'hFD; #1;
    checks++;
    if (kd !== 5'b11110) begin errors++; $display("FAIL watchdog_recover got=%b exp=%b", kd, 5'b11110); end
    checks++;
    if (err_pulses - e0 != 1) begin
      errors++; $display("FAIL watchdog_err_once got=%0d exp=1", err_pulses - e0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_key();
    test_multi_row();
    test_parity_error();
    test_framing_error();
    test_ext_and_overrun();
    test_random();
    test_reset_mid_frame();
`ifdef PS2_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
